// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
// Holds the control states, width helpers and saturation limits.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int addr_width(input int n_taps);
        return (n_taps > 1) ? $clog2(n_taps) : 1;
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// Multiply-accumulate datapath with round-half-up and saturation back to sample width.
// The rounded result is combinational from the accumulator; the top registers it.
module fir_mac_sat import fir_pkg::*; #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 15,
    parameter int ACC_W     = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [COEF_W-1:0] c_i,
    output logic [DATA_W-1:0] y_o,
    output logic              sat_o
);

    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (COEF_FRAC - 1);
    localparam logic signed [ACC_W:0] HI   = (ACC_W + 1)'(sat_max(DATA_W));
    localparam logic signed [ACC_W:0] LO   = (ACC_W + 1)'(sat_min(DATA_W));

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W:0]   biased, shifted;

    assign prod = $signed(x_i) * $signed(c_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // One guard bit so the rounding bias can never wrap the accumulator.
    assign biased  = {acc_q[ACC_W-1], acc_q} + HALF;
    assign shifted = biased >>> COEF_FRAC;

    always_comb begin
        y_o   = shifted[DATA_W-1:0];
        sat_o = 1'b0;
        if (shifted > HI) begin
            y_o   = HI[DATA_W-1:0];
            sat_o = 1'b1;
        end else if (shifted < LO) begin
            y_o   = LO[DATA_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fir_filter_tdm.sv
// Single-multiplier multi-channel FIR: one sample in, N_TAPS MAC cycles, round, present.
// Control FSM, coefficient store and per-channel circular delay lines live here.
module fir_filter_tdm import fir_pkg::*; #(
    parameter  int DATA_W    = 16,
    parameter  int COEF_W    = 16,
    parameter  int COEF_FRAC = 15,
    parameter  int N_TAPS    = 65,
    parameter  int N_CH      = 2,
    parameter  int ACC_W     = 48,
    localparam int CH_W      = ch_width(N_CH),
    localparam int AW        = addr_width(N_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CH_W-1:0]   s_ch,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CH_W-1:0]   m_ch,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy,
    output logic              sat,
    output logic              ch_err
);

    fir_state_e          state_q, state_d;
    logic                accept, ch_ok, last_tap, rnd_sat;
    logic [CH_W-1:0]     ch_q, m_ch_q;
    logic [AW-1:0]       base_q, k_q, rd_idx;
    logic [DATA_W-1:0]   m_data_q, rnd_data;
    logic                sat_q, ch_err_q;
    logic [AW-1:0]       ptr_all [N_CH];
    logic [DATA_W-1:0]   tap_all [N_CH];
    logic [COEF_W-1:0]   coef_q  [N_TAPS];

    assign accept   = s_valid && (state_q == ST_IDLE);
    assign ch_ok    = 32'(s_ch) < N_CH;
    assign last_tap = (k_q == AW'(N_TAPS - 1));

    // Tap k reads the sample k positions older than the newest one, wrapping the ring.
    always_comb begin
        if (k_q > base_q) begin
            rd_idx = AW'(32'(base_q) + N_TAPS - 32'(k_q));
        end else begin
            rd_idx = base_q - k_q;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [AW-1:0]     ptr_q;
            logic [DATA_W-1:0] line_q [N_TAPS];
            logic              wr_en;

            assign wr_en = accept && ch_ok && (s_ch == CH_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_q <= '0;
                    for (int i = 0; i < N_TAPS; i++) begin
                        line_q[i] <= '0;
                    end
                end else if (wr_en) begin
                    line_q[ptr_q] <= s_data;
                    ptr_q <= (ptr_q == AW'(N_TAPS - 1)) ? '0 : ptr_q + AW'(1);
                end
            end

            assign ptr_all[gi] = ptr_q;
            assign tap_all[gi] = line_q[rd_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if ((state_q == ST_IDLE) && coef_we && (32'(coef_addr) < N_TAPS)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    fir_mac_sat #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (state_q == ST_MAC),
        .x_i   (tap_all[ch_q]),
        .c_i   (coef_q[k_q]),
        .y_o   (rnd_data),
        .sat_o (rnd_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (s_valid && ch_ok) state_d = ST_MAC;
            ST_MAC:   if (last_tap) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_OUT;
            ST_OUT:   if (m_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_q == ST_IDLE);
        busy    = (state_q != ST_IDLE);
        m_valid = (state_q == ST_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q     <= '0;
            base_q   <= '0;
            k_q      <= '0;
            m_data_q <= '0;
            m_ch_q   <= '0;
            sat_q    <= 1'b0;
            ch_err_q <= 1'b0;
        end else begin
            if (accept && ch_ok) begin
                ch_q   <= s_ch;
                base_q <= ptr_all[s_ch];
            end
            if (accept && !ch_ok) begin
                ch_err_q <= 1'b1;
            end
            if (state_q == ST_MAC) begin
                k_q <= last_tap ? '0 : k_q + AW'(1);
            end
            if (state_q == ST_ROUND) begin
                m_data_q <= rnd_data;
                m_ch_q   <= ch_q;
                if (rnd_sat) sat_q <= 1'b1;
            end
        end
    end

    assign m_data = m_data_q;
    assign m_ch   = m_ch_q;
    assign sat    = sat_q;
    assign ch_err = ch_err_q;

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Randomised and directed bench for fir_filter_tdm against a newest-first history model.
module tb_fir_filter_tdm;

    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int FR  = 15;
    localparam int NT  = 65;
    localparam int NCH = 3;
    localparam int CHW = 2;
    localparam int AW  = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_valid, s_ready;
    logic [DW-1:0]  s_data;
    logic [CHW-1:0] s_ch;
    logic           m_valid, m_ready;
    logic [DW-1:0]  m_data;
    logic [CHW-1:0] m_ch;
    logic           coef_we;
    logic [AW-1:0]  coef_addr;
    logic [CW-1:0]  coef_data;
    logic           busy, sat, ch_err;

    fir_filter_tdm #(
        .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(FR), .N_TAPS(NT), .N_CH(NCH), .ACC_W(48)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .sat(sat), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: history kept newest-first, output = rounded, clamped dot product.
    int coef_m [NT];
    int hist_m [NCH][NT];
    bit sat_m;

    function automatic void model_reset();
        for (int k = 0; k < NT; k++) begin
            coef_m[k] = 0;
            for (int c = 0; c < NCH; c++) hist_m[c][k] = 0;
        end
        sat_m = 1'b0;
    endfunction

    function automatic int model_push(input int ch, input logic [DW-1:0] d);
        longint acc;
        longint r;
        for (int k = NT - 1; k > 0; k--) hist_m[ch][k] = hist_m[ch][k-1];
        hist_m[ch][0] = int'($signed(d));
        acc = 0;
        for (int k = 0; k < NT; k++) acc += longint'(hist_m[ch][k]) * longint'(coef_m[k]);
        r = (acc + (64'sd1 <<< (FR - 1))) >>> FR;
        if (r > 32767) begin r = 32767; sat_m = 1'b1; end
        if (r < -32768) begin r = -32768; sat_m = 1'b1; end
        return int'(r);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; coef_we = 1'b0; m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int addr, input logic [CW-1:0] d);
        coef_we = 1'b1; coef_addr = AW'(addr); coef_data = d;
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        if (addr < NT) coef_m[addr] = int'($signed(d));
    endtask

    task automatic load_coefs(input int mode);
        for (int k = 0; k < NT; k++) begin
            if (mode == 0)      write_coef(k, CW'(2 * k + 1));
            else if (mode == 1) write_coef(k, 16'h7FFF);
            else                write_coef(k, CW'($urandom_range(0, 16'hFFFF)));
        end
    endtask

    // mode 0 plain, 1 coefficient writes during MAC, 2 coefficient write on the accept edge.
    task automatic send(input int ch, input logic [DW-1:0] d, input int hold,
                        input int mode, output int got_y);
        int lat;
        int exp_y;
        bit got_v;
        got_y = 0;
        if (hold > 0) m_ready = 1'b0;
        for (int i = 0; i < 300 && !s_ready; i++) @(negedge clk);
        if (!s_ready) check("ready_timeout", 0, 1);
        s_valid = 1'b1; s_data = d; s_ch = CHW'(ch);
        if (mode == 2) begin
            coef_we = 1'b1; coef_addr = '0; coef_data = 16'h0100;
            coef_m[0] = 256;
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; coef_we = 1'b0;
        exp_y = model_push(ch, d);
        lat = 1;
        got_v = 1'b0;
        for (int i = 0; i < NT + 20; i++) begin
            if (m_valid) begin
                got_v = 1'b1;
                break;
            end
            if (mode == 1 && lat <= 3) begin
                coef_we = 1'b1; coef_addr = AW'(lat - 1); coef_data = 16'h7FFF;
            end else begin
                coef_we = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        coef_we = 1'b0;
        if (!got_v) begin
            check("mvalid_timeout", 0, 1);
        end else begin
            check("latency", lat, NT + 2);
            got_y = int'($signed(m_data));
            check("m_data", got_y, exp_y);
            check("m_ch", m_ch, ch);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                check("bp_valid", m_valid, 1);
                check("bp_data", int'($signed(m_data)), exp_y);
                check("bp_ch", m_ch, ch);
                check("bp_s_ready", s_ready, 0);
            end
            m_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("post_out_ready", {m_valid, s_ready}, 2'b01);
        end
    endtask

    int y;
    bit seen;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_ch = '0; m_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_ch", m_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        check("rst_ch_err", ch_err, 0);

        // Impulse through coef 2k+1
        load_coefs(0);
        for (int k = 0; k < NT; k++) begin
            send(0, (k == 0) ? 16'h4000 : 16'h0000, 0, 0, y);
            check("impulse", y, k + 1);
        end
        check("impulse_sat", sat, 0);

        // Positive and negative saturation
        do_reset();
        load_coefs(1);
        for (int k = 0; k < NT; k++) send(0, 16'h7FFF, 0, 0, y);
        check("sat_pos_last", y, 32767);
        check("sat_pos_flag", sat, 1);
        do_reset();
        load_coefs(1);
        for (int k = 0; k < NT; k++) send(0, 16'h8000, 0, 0, y);
        check("sat_neg_last", y, -32768);
        check("sat_neg_flag", sat, 1);

        // Interleaved channels
        do_reset();
        load_coefs(0);
        for (int k = 0; k < NT; k++) begin
            send(0, (k == 0) ? 16'h4000 : 16'h0000, 0, 0, y);
            check("ch0_impulse", y, k + 1);
            send(1, 16'h0000, 0, 0, y);
            check("ch1_zero", y, 0);
        end

        // Backpressure, coefficient write timing, out-of-range address
        send(1, 16'h1234, 10, 0, y);
        send(0, 16'h2000, 0, 1, y);
        send(2, 16'h0800, 0, 2, y);
        write_coef(100, 16'h7FFF);
        send(0, 16'h4000, 0, 0, y);
        send(1, 16'hC000, 0, 0, y);

        // Bad channel index
        s_valid = 1'b1; s_ch = CHW'(NCH); s_data = 16'h7FFF;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        check("badch_s_ready", s_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < NT + 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_valid || busy) seen = 1'b1;
        end
        check("badch_no_output", seen, 0);
        check("badch_ch_err", ch_err, 1);
        send(1, 16'h0100, 0, 0, y);

        // Reset at MAC cycle 5
        s_valid = 1'b1; s_ch = '0; s_data = 16'h4000;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_flags", {sat, ch_err}, 0);
        seen = 1'b0;
        for (int i = 0; i < NT + 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        check("mid_rst_no_output", seen, 0);
        load_coefs(0);
        for (int k = 0; k < NT; k++) begin
            send(0, (k == 0) ? 16'h4000 : 16'h0000, 0, 0, y);
            check("impulse_after_rst", y, k + 1);
        end

        // Random coefficients, data, channels and occasional backpressure
        load_coefs(2);
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, NCH - 1), DW'($urandom_range(0, 16'hFFFF)),
                 ($urandom_range(0, 7) == 0) ? 2 : 0, 0, y);
        end
        check("random_sat", sat, sat_m);
        check("random_ch_err", ch_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_filter_tdm.md
FIR_FILTER_TDM -- requirements
Module: fir_filter_tdm

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width, signed Q1.(DATA_W-1).
REQ-002 SHALL have parameter COEF_W, default 16: coefficient width, signed, COEF_FRAC fractional bits.
REQ-003 SHALL have parameter COEF_FRAC, default 15: product shift back to sample format.
REQ-004 SHALL have parameter N_TAPS, default 65: taps per channel, range 2..256.
REQ-005 SHALL have parameter N_CH, default 2: independent channels sharing one coefficient set, range 1..8.
REQ-006 SHALL have parameter ACC_W, default 48: accumulator width, at least DATA_W+COEF_W+clog2(N_TAPS).
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 s_valid / s_ready  in / out  1 / 1  input sample handshake.
REQ-010 s_data / s_ch  in / in  DATA_W / CH_W  input sample and channel index; CH_W = max(1, clog2(N_CH)).
REQ-011 m_valid / m_ready  out / in  1 / 1  output sample handshake.
REQ-012 m_data / m_ch  out / out  DATA_W / CH_W  filtered sample and its channel.
REQ-013 coef_we / coef_addr / coef_data  in / in / in  1 / clog2(N_TAPS) / COEF_W  coefficient write port.
REQ-014 busy / sat / ch_err  out / out / out  1 / 1 / 1  computing; sticky saturation; sticky bad-channel.

Function
REQ-015 SHALL be a single-multiplier time-multiplexed FIR: states IDLE, MAC, ROUND, OUT.
REQ-016 IDLE: s_ready=1; on s_valid&&s_ready, write s_data into channel s_ch delay line at that channel's write pointer, latch s_ch, clear acc, go to MAC.
REQ-017 MAC: exactly N_TAPS cycles, one product per cycle: acc += x[n-k]*coef[k], k=0..N_TAPS-1, full-precision signed.
REQ-018 Delay line per channel SHALL be circular; pointer wraps N_TAPS-1 -> 0, advanced only on accepted sample of that channel.
REQ-019 ROUND: one cycle: acc + 2^(COEF_FRAC-1), arithmetic shift right COEF_FRAC, saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; clamp sets sat.
REQ-020 OUT: m_valid=1, m_data/m_ch stable until m_ready; on m_valid&&m_ready return to IDLE the same edge.
REQ-021 Latency: accept edge to m_valid = N_TAPS+2 cycles; throughput one sample per N_TAPS+3 cycles with m_ready held high.
REQ-022 busy=1 in MAC, ROUND, OUT; s_ready=0 in those states.
REQ-023 s_ch >= N_CH: sample accepted and discarded, no output, no history change, ch_err set, remain IDLE.
REQ-024 Coefficient write SHALL take effect only in IDLE; coef_we in other states ignored; simultaneous coef_we and sample accept: write applies before the MAC begins.
REQ-025 coef_addr >= N_TAPS SHALL be ignored.
REQ-026 sat and ch_err SHALL clear only on rst.

Reset
REQ-027 rst SHALL force IDLE, s_ready=1 on the following cycle, m_valid=0, m_data=0, m_ch=0, busy=0, sat=0, ch_err=0.
REQ-028 rst SHALL zero all delay lines and write pointers; coefficients SHALL reset to 0.
REQ-029 rst mid-MAC or mid-OUT SHALL abort; the pending output is never presented.

Structure
REQ-030 Shared package fir_pkg SHALL hold state enum, CH_W/address-width functions, saturation limit constants.
REQ-031 One sub-module fir_mac_sat (multiply-accumulate, round, saturate datapath) SHALL be instantiated; control FSM and storage in top.

Verification
REQ-032 Impulse: coef[k]=2k+1, ch0 input 0x4000 then N_TAPS-1 zeros -> outputs k+1 for k=0..N_TAPS-1, sat=0.
REQ-033 Saturation: all coef 0x7FFF, N_TAPS inputs 0x7FFF -> last output 0x7FFF, sat=1; repeat with 0x8000 inputs -> 0x8000.
REQ-034 Channels: interleave ch0 impulse 0x4000 with ch1 zeros -> ch1 outputs all 0, ch0 matches REQ-032, m_ch correct.
REQ-035 Backpressure: m_ready low 10 cycles in OUT -> m_data/m_ch stable, s_ready=0, no sample lost.
REQ-036 Coefficient write during MAC ignored; s_ch=N_CH -> ch_err=1, no m_valid.
REQ-037 rst at MAC cycle 5 -> no m_valid; next impulse reproduces REQ-032 from zeroed history.
